md_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, consuming operand A (`srcAE`) and the selected operand B (`srcBE`, output of the ALU operand-B mux). Executes MULT/MULTU/DIV/DIVU into private HI/LO registers over several cycles, and executes MTHI/MTLO in one cycle. Raises a busy/stall signal so the hazard unit can hold MFHI/MFLO and further MD ops until results land.

---
 rtl/md_unit.sv | 173 +++++++++++++++++
 tb/tb_md_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Iterative multiply/divide unit for the EX stage.
// Owns HI/LO; multi-cycle ops hold busyE until the result is written.
module md_unit #(
    parameter int unsigned MUL_LATENCY = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startE,
    input  logic [2:0]  mdopE,
    input  logic        flushE,
    input  logic [31:0] srcAE,
    input  logic [31:0] srcBE,
    output logic        busyE,
    output logic        mdstallE,
    output logic [31:0] hiE,
    output logic [31:0] loE
);

    localparam logic [5:0] DIV_CYCLES = 6'd32;
    localparam logic [5:0] MUL_LAST   = 6'(MUL_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic        sgn_q, sgn_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept;
    logic        sdiv;
    logic [5:0]  cnt_inc;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod_s, prod_u;
    logic [32:0] rem_sh, rem_sub;
    logic [31:0] quo_n, rem_n;
    logic [31:0] q_fin, r_fin;

    always_comb begin
        accept  = startE & ~flushE & (state_q == S_IDLE) & ~reset;
        sdiv    = (mdopE == 3'd3);
        cnt_inc = cnt_q + 6'd1;
        a_mag   = (sdiv & srcAE[31]) ? -srcAE : srcAE;
        b_mag   = (sdiv & srcBE[31]) ? -srcBE : srcBE;
        prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u  = {32'd0, a_q} * {32'd0, b_q};
        // One restoring step: shift in the next dividend bit, subtract if it fits
        rem_sh  = {rem_q, quo_q[31]};
        rem_sub = rem_sh - {1'b0, b_q};
        if (!rem_sub[32]) begin
            rem_n = rem_sub[31:0];
            quo_n = {quo_q[30:0], 1'b1};
        end else begin
            rem_n = rem_sh[31:0];
            quo_n = {quo_q[30:0], 1'b0};
        end
        q_fin = qneg_q ? -quo_n : quo_n;
        r_fin = rneg_q ? -rem_n : rem_n;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (mdopE)
                        3'd1, 3'd2: begin
                            state_d = S_MUL;
                            cnt_d   = 6'd0;
                            a_d     = srcAE;
                            b_d     = srcBE;
                            sgn_d   = (mdopE == 3'd1);
                        end
                        3'd3, 3'd4: begin
                            state_d = S_DIV;
                            cnt_d   = 6'd0;
                            a_d     = srcAE;
                            b_d     = b_mag;
                            quo_d   = a_mag;
                            rem_d   = 32'd0;
                            qneg_d  = sdiv & (srcAE[31] ^ srcBE[31]);
                            rneg_d  = sdiv & srcAE[31];
                        end
                        3'd5:    hi_d = srcAE;
                        3'd6:    lo_d = srcAE;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                cnt_d = cnt_inc;
                if (cnt_inc == MUL_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 6'd0;
                    hi_d    = sgn_q ? prod_s[63:32] : prod_u[63:32];
                    lo_d    = sgn_q ? prod_s[31:0] : prod_u[31:0];
                end
            end
            S_DIV: begin
                cnt_d = cnt_inc;
                quo_d = quo_n;
                rem_d = rem_n;
                if (cnt_inc == DIV_CYCLES) begin
                    state_d = S_IDLE;
                    cnt_d   = 6'd0;
                    // Zero divisor: b_q holds the magnitude, so this covers both signednesses
                    if (b_q == 32'd0) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = a_q;
                    end else begin
                        lo_d = q_fin;
                        hi_d = r_fin;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busyE    = (state_q != S_IDLE);
    assign mdstallE = busyE | (startE & ~flushE & (mdopE >= 3'd1) & (mdopE <= 3'd4));
    assign hiE      = hi_q;
    assign loE      = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO/busy length,
// a negedge monitor pops and compares when a result lands.
module tb_md_unit;

    localparam int MUL_LAT = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startE = 1'b0;
    logic [2:0]  mdopE = 3'd0;
    logic        flushE = 1'b0;
    logic [31:0] srcAE = 32'd0;
    logic [31:0] srcBE = 32'd0;
    logic        busyE;
    logic        mdstallE;
    logic [31:0] hiE;
    logic [31:0] loE;

    md_unit #(.MUL_LATENCY(MUL_LAT)) dut (
        .clk(clk),
        .reset(reset),
        .startE(startE),
        .mdopE(mdopE),
        .flushE(flushE),
        .srcAE(srcAE),
        .srcBE(srcBE),
        .busyE(busyE),
        .mdstallE(mdstallE),
        .hiE(hiE),
        .loE(loE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the architectural HI/LO
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
        int          sa, sb_;
        longint      p, q, r;
        logic [63:0] pu;
        sa  = a;
        sb_ = b;
        cyc = 0;
        case (op)
            3'd1: begin
                p = longint'(sa) * longint'(sb_);
                hi_m = p[63:32]; lo_m = p[31:0]; cyc = MUL_LAT;
            end
            3'd2: begin
                pu = {32'd0, a} * {32'd0, b};
                hi_m = pu[63:32]; lo_m = pu[31:0]; cyc = MUL_LAT;
            end
            3'd3: begin
                if (b == 0) begin
                    lo_m = 32'hFFFF_FFFF; hi_m = a;
                end else begin
                    q = longint'(sa) / longint'(sb_);
                    r = longint'(sa) % longint'(sb_);
                    lo_m = q[31:0]; hi_m = r[31:0];
                end
                cyc = 32;
            end
            3'd4: begin
                if (b == 0) begin
                    lo_m = 32'hFFFF_FFFF; hi_m = a;
                end else begin
                    lo_m = a / b; hi_m = a % b;
                end
                cyc = 32;
            end
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busyE && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busyE) chk("idle_timeout", 64'(busyE), 64'd0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic fl);
        int   cyc;
        exp_t e;
        wait_idle();
        startE = 1'b1; mdopE = op; srcAE = a; srcBE = b; flushE = fl;
        #1;
        chk("stall", 64'(mdstallE), 64'(!fl && op >= 3'd1 && op <= 3'd4));
        if (!fl && op >= 3'd1 && op <= 3'd6) begin
            model(op, a, b, cyc);
            e.hi = hi_m; e.lo = lo_m; e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        startE = 1'b0; flushE = 1'b0; mdopE = 3'd0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busyE) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    // Monitor
    logic prev_busy = 1'b0;
    logic mt_pend = 1'b0;
    int   bcnt = 0;

    task automatic pop_cmp(input int cyc_seen, input logic chk_cyc);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("hi", 64'(hiE), 64'(e.hi));
            chk("lo", 64'(loE), 64'(e.lo));
            if (chk_cyc) chk("busy_cycles", 64'(cyc_seen), 64'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
            mt_pend   = 1'b0;
            bcnt      = 0;
        end else begin
            if (mt_pend) begin
                pop_cmp(0, 1'b0);
                chk("mt_busy", 64'(busyE), 64'd0);
                mt_pend = 1'b0;
            end
            if (busyE) bcnt++;
            if (prev_busy && !busyE) begin
                pop_cmp(bcnt, 1'b1);
                bcnt = 0;
            end
            if (startE && !flushE && !busyE && (mdopE == 3'd5 || mdopE == 3'd6))
                mt_pend = 1'b1;
            prev_busy = busyE;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'h2};

    function automatic logic [31:0] rnd_op();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 300));
        return $urandom;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("stall_in_reset", 64'(mdstallE), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_hi", 64'(hiE), 64'd0);
        chk("rst_lo", 64'(loE), 64'd0);
        chk("rst_busy", 64'(busyE), 64'd0);

        issue(3'd5, 32'h1234_5678, 32'd0, 1'b0);
        chk("mthi_nobusy", 64'(busyE), 64'd0);

        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        issue(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(3'd4, 32'd100, 32'd7, 1'b0);
        issue(3'd3, 32'd5, 32'd0, 1'b0);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        issue(3'd6, 32'h0BAD_F00D, 32'd0, 1'b0);
        drain();

        // Flushed start must not be accepted
        issue(3'd4, 32'd50, 32'd3, 1'b1);
        chk("flush_nobusy", 64'(busyE), 64'd0);

        // Pulse MTLO while busy: must be ignored
        issue(3'd4, 32'd1000, 32'd7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        startE = 1'b1; mdopE = 3'd6; srcAE = 32'h0000_AAAA;
        @(posedge clk); #1;
        startE = 1'b0; mdopE = 3'd0;
        drain();

        // Reset in the middle of a divide
        issue(3'd4, 32'hFFFF_0000, 32'd13, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        hi_m = 32'd0; lo_m = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", 64'(busyE), 64'd0);
        chk("midrst_hi", 64'(hiE), 64'd0);
        chk("midrst_lo", 64'(loE), 64'd0);
        issue(3'd2, 32'd3, 32'd4, 1'b0);
        drain();

        // Random mix, issued back-to-back as soon as busy drops
        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(1, 6)), rnd_op(), rnd_op(), ($urandom_range(0, 7) == 0));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
